// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch/data request ports and memory port of the mem_arbiter
interface mem_arbiter_if;
   logic        if_req;
   logic [15:0] if_addr;
   logic        if_ack;
   logic [15:0] if_rdata;
   logic        d_req;
   logic        d_wr;
   logic [15:0] d_addr;
   logic [15:0] d_wdata;
   logic        d_ack;
   logic [15:0] d_rdata;
   logic        mem_en;
   logic        mem_wr;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic        busy;

   modport master (
      output if_req, if_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
      input  if_ack, if_rdata, d_ack, d_rdata, mem_en, mem_wr, mem_addr, mem_wdata, busy
   );

   modport slave (
      input  if_req, if_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
      output if_ack, if_rdata, d_ack, d_rdata, mem_en, mem_wr, mem_addr, mem_wdata, busy
   );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter onto one memory port; MEM_ARB_STARVE_EN adds a fetch starvation guard
module mem_arbiter #(
   parameter int MEM_LAT    = 1,
   parameter int STARVE_MAX = 4
) (
   input  logic         clk,
   input  logic         rst,
   mem_arbiter_if.slave bus
);

   if (MEM_LAT < 0 || MEM_LAT > 15 || STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_param
      $error("mem_arbiter: parameter out of range");
   end

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

   state_t      state, state_nxt;
   logic        owner_d;
   logic        lat_wr;
   logic [15:0] lat_addr;
   logic [15:0] lat_wdata;
   logic [15:0] if_rdata_q;
   logic [15:0] d_rdata_q;
   logic [3:0]  wait_cnt;
   logic        any_req;
   logic        grant_d;
   logic        force_if;
   logic        capture;

`ifdef MEM_ARB_STARVE_EN
   logic [3:0] starve_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt <= 4'd0;
      end else if (state == IDLE && any_req) begin
         if (grant_d && bus.if_req) starve_cnt <= starve_cnt + 4'd1;
         else                       starve_cnt <= 4'd0;
      end
   end

   assign force_if = bus.if_req && bus.d_req && (starve_cnt == 4'(STARVE_MAX));
`else
   assign force_if = 1'b0;
`endif

   assign any_req = bus.if_req || bus.d_req;
   assign grant_d = bus.d_req && !force_if;
   // Read data lands in the last WAIT cycle, or right after ISSUE for a zero-latency memory.
   assign capture = (state == WAIT && wait_cnt == 4'd0) || (state == ISSUE && MEM_LAT == 0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (any_req) state_nxt = ISSUE;
         ISSUE:   state_nxt = (MEM_LAT > 0) ? WAIT : ACK;
         WAIT:    if (wait_cnt == 4'd0) state_nxt = ACK;
         ACK:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.mem_en = 1'b0;
      bus.mem_wr = 1'b0;
      bus.if_ack = 1'b0;
      bus.d_ack  = 1'b0;
      bus.busy   = (state != IDLE);
      case (state)
         ISSUE: begin
            bus.mem_en = 1'b1;
            bus.mem_wr = lat_wr;
         end
         ACK: begin
            bus.d_ack  = owner_d;
            bus.if_ack = !owner_d;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner_d    <= 1'b0;
         lat_wr     <= 1'b0;
         lat_addr   <= 16'd0;
         lat_wdata  <= 16'd0;
         if_rdata_q <= 16'd0;
         d_rdata_q  <= 16'd0;
         wait_cnt   <= 4'd0;
      end else begin
         if (state == IDLE && any_req) begin
            owner_d   <= grant_d;
            lat_wr    <= grant_d && bus.d_wr;
            lat_addr  <= grant_d ? bus.d_addr : bus.if_addr;
            lat_wdata <= grant_d ? bus.d_wdata : 16'd0;
         end
         if (state == ISSUE)
            wait_cnt <= 4'(MEM_LAT - 1);
         else if (state == WAIT && wait_cnt != 4'd0)
            wait_cnt <= wait_cnt - 4'd1;
         if (capture && !lat_wr) begin
            if (owner_d) d_rdata_q  <= bus.mem_rdata;
            else         if_rdata_q <= bus.mem_rdata;
         end
      end
   end

   assign bus.mem_addr  = lat_addr;
   assign bus.mem_wdata = lat_wdata;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.d_rdata   = d_rdata_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter sharing one single-ported instruction/data memory between the fetch stage and the memory stage. It accepts read requests from fetch and read/write requests from the data path, serializes them onto the memory port, and returns read data with a one-cycle acknowledge per access. Data accesses have priority; an optional starvation guard bounds how long fetch can be locked out.

## Interface
- MEM_LAT, 1: memory read latency in cycles from the cycle `mem_en` is high to the cycle `mem_rdata` is valid; range 0..15.
- STARVE_MAX, 4: consecutive contested data grants before fetch is forced; range 1..15. Used only with `MEM_ARB_STARVE_EN`.

- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch read request; held until `if_ack`.
- if_addr  in  16  fetch address; stable while `if_req`.
- if_ack  out  1  one-cycle pulse: fetch access complete.
- if_rdata  out  16  fetch read data; valid in the `if_ack` cycle, held until the next fetch ack.
- d_req  in  1  data request; held until `d_ack`.
- d_wr  in  1  1 = write, 0 = read; stable while `d_req`.
- d_addr  in  16  data address.
- d_wdata  in  16  write data.
- d_ack  out  1  one-cycle pulse: data access complete.
- d_rdata  out  16  data read data; valid in the `d_ack` cycle, held until the next data read ack.
- mem_en  out  1  memory enable.
- mem_wr  out  1  memory write strobe.
- mem_addr  out  16  memory address.
- mem_wdata  out  16  memory write data.
- mem_rdata  in  16  memory read data.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - Samples `d_req` and `if_req` at the clock edge.
  - If either is high, latch the winner's owner, address, write flag and write data, then go to ISSUE.
  - Otherwise stay in IDLE.
- Arbitration: data wins when both requests are high, unless the starvation guard forces fetch (see Configuration).
- ISSUE (1 cycle):
  - `mem_en=1`.
  - `mem_wr=1` only for a data write.
  - Next state is WAIT if MEM_LAT>0, otherwise ACK.
- WAIT (MEM_LAT cycles): 4-bit down-counter. `mem_rdata` is captured into the owner's rdata register at the end of the last WAIT cycle. When MEM_LAT=0, capture happens at the end of ISSUE.
- ACK (1 cycle):
  - Owner's ack is 1.
  - Next state is IDLE unconditionally.
  - Requests are not sampled in ACK. A requester may drop `req` or present a new request from the cycle after ack.
- `mem_addr` and `mem_wdata` drive the latched values from ISSUE through ACK and hold them in IDLE.
- `mem_en` and `mem_wr` are 0 outside ISSUE.
- Writes:
  - `mem_rdata` is not captured.
  - `d_rdata` keeps its previous value.
  - `d_ack` still pulses after MEM_LAT.
- `if_ack` and `d_ack` are never high in the same cycle.

## Timing
- Reset values (asynchronous, immediate): state IDLE; all outputs 0, including `if_rdata`, `d_rdata`, `mem_addr` and `mem_wdata`; starvation counter 0.
- Latency: the request is sampled at edge E, ISSUE is the cycle after E, and ack arrives MEM_LAT+1 cycles after ISSUE.
- Back-to-back throughput: one access per MEM_LAT+3 cycles.
- Reset mid-operation: the in-flight access is dropped with no ack, and `mem_en` falls immediately. A request re-presented after reset is serviced normally.
- A requester that drops `req` before ack is a protocol violation; the arbiter still completes the latched access and pulses ack.

## Configuration
- `MEM_ARB_STARVE_EN` defined:
  - A 4-bit counter increments on each data grant made while `if_req` was also high.
  - The counter clears on any fetch grant, and on a data grant made with `if_req` low.
  - When the counter equals STARVE_MAX and both requests are high, fetch wins and the counter clears.
- `MEM_ARB_STARVE_EN` undefined: strict data priority, no counter logic, STARVE_MAX ignored.

## Test plan
All scenarios use MEM_LAT=1.
- Reset: assert `rst` mid-cycle → every output 0 before the next edge; `busy=0`.
- Fetch read alone: `if_req=1`, `if_addr=0x0010`, memory returns 0xA5A5 → ISSUE with `mem_addr=0x0010`, `mem_en=1`, `mem_wr=0`; `if_ack` is a single pulse 2 cycles later with `if_rdata=0xA5A5` held afterwards.
- Contention: `d_req` (read 0x0200 → 0x1111) and `if_req` (0x0020 → 0x2222) rise together → `d_ack` first with `d_rdata=0x1111`; `if_ack` exactly 4 cycles later with `if_rdata=0x2222`.
- Data write: `d_wr=1`, `d_addr=0x0100`, `d_wdata=0x1234`, prior `d_rdata=0x1111` → `mem_wr=1` only in the ISSUE cycle with `mem_wdata=0x1234`; `d_ack` 2 cycles later; `d_rdata` stays 0x1111.
- Starvation (macro on, STARVE_MAX=2): `d_req` and `if_req` held high continuously → grant order D, D, I, D, D, I. With the macro off the order is D only, and fetch is never acked.
- Reset during WAIT of a fetch read → no `if_ack`; state IDLE. A re-issued request to 0x0030 completes with ack 2 cycles after its ISSUE.
